rr_mux_arbiter: RTL and testbench

Round-robin arbiter and sequencer for a shared 4:1 data mux: four requesters each present a DW-bit word with a valid/ready handshake, and the block grants one per transfer, drives the mux select and registers the chosen word into a single-entry output stage toward one consumer. It sits in front of the 4:1 select datapath and owns the select line, so the mux is shared fairly instead of being driven by static stimulus.

---
 rtl/rr_mux_arbiter_pkg.sv | 17 +
 rtl/rr_mux_arbiter_mux4_data.sv | 26 ++
 rtl/rr_mux_arbiter.sv | 99 +++++++++
 tb/tb_rr_mux_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin 4:1 mux arbiter: state encoding,
// requester count and requester index constants.
package rr_mux_arbiter_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam int unsigned NREQ = 4;

    localparam logic [1:0] REQ_A = 2'd0;
    localparam logic [1:0] REQ_B = 2'd1;
    localparam logic [1:0] REQ_C = 2'd2;
    localparam logic [1:0] REQ_D = 2'd3;

endpackage

// File: rtl/rr_mux_arbiter_mux4_data.sv
// Combinational 4:1 DW-bit data mux, steered by the arbiter's grant index.
module mux4_data
    import rr_mux_arbiter_pkg::*;
#(
    parameter int unsigned DW = 2
) (
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    input  logic [DW-1:0] in_c,
    input  logic [DW-1:0] in_d,
    input  logic [1:0]    sel,
    output logic [DW-1:0] y
);

    always_comb begin
        y = '0;
        case (sel)
            REQ_A:   y = in_a;
            REQ_B:   y = in_b;
            REQ_C:   y = in_c;
            REQ_D:   y = in_d;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for four valid/ready requesters feeding a shared 4:1 mux,
// with a single-entry registered output stage toward one consumer.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int unsigned DW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    in_valid,
    output logic [3:0]    in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    input  logic [DW-1:0] in_c,
    input  logic [DW-1:0] in_d,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    out_src,
    output logic [1:0]    sel
);

    state_e        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [DW-1:0] data_q, data_d;
    logic [1:0]    src_q, src_d;

    logic [1:0]    grant;
    logic [1:0]    idx;
    logic          any_req;
    logic          cap_en;
    logic          capture;
    logic [DW-1:0] mux_y;

    // Priority search starting at the pointer; falls back to ptr when idle.
    always_comb begin
        grant   = ptr_q;
        any_req = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = ptr_q + 2'(k);
            if (!any_req && in_valid[idx]) begin
                grant   = idx;
                any_req = 1'b1;
            end
        end
    end

    assign cap_en  = (state_q == ST_EMPTY) || out_ready;
    assign capture = cap_en && any_req;

    // Outputs are forced quiet while reset is held so no requester sees a handshake.
    assign in_ready  = (rst_n && capture) ? (4'b0001 << grant) : '0;
    assign sel       = rst_n ? grant : '0;
    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_src   = src_q;

    mux4_data #(
        .DW(DW)
    ) u_mux (
        .in_a(in_a),
        .in_b(in_b),
        .in_c(in_c),
        .in_d(in_d),
        .sel (grant),
        .y   (mux_y)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        src_d   = src_q;
        if (capture) begin
            state_d = ST_FULL;
            ptr_d   = grant + 2'd1;
            data_d  = mux_y;
            src_d   = grant;
        end else if ((state_q == ST_FULL) && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: directed scenarios plus random traffic
// against a queue-based round-robin reference model.
module tb_rr_mux_arbiter;

    localparam int unsigned DW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    in_valid = '0;
    logic [3:0]    in_ready;
    logic [DW-1:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [1:0]    out_src;
    logic [1:0]    sel;

    rr_mux_arbiter #(
        .DW(DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_c     (in_c),
        .in_d     (in_d),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_src  (out_src),
        .sel      (sel)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [1:0]    s;
    } exp_t;

    exp_t sb[$];

    int nchk = 0;
    int npass = 0;

    // Requester-side stimulus state: a pending word stays presented until granted.
    logic          pend[4];
    logic [DW-1:0] word[4];
    logic          ordy;
    logic          rst_req;

    // Reference model state.
    int   m_ptr;
    logic m_full;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_full = 1'b0;
        sb.delete();
    endtask

    task automatic step();
        int   g;
        int   exp_ready;
        int   exp_sel;
        logic cap_en;
        @(negedge clk);
        rst_n     = rst_req;
        in_valid  = {pend[3], pend[2], pend[1], pend[0]};
        in_a      = word[0];
        in_b      = word[1];
        in_c      = word[2];
        in_d      = word[3];
        out_ready = ordy;
        #1;
        if (!rst_req) begin
            model_reset();
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_in_ready", int'(in_ready), 0);
            chk("rst_sel", int'(sel), 0);
            return;
        end
        g = -1;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr + k) % 4;
            if (g < 0 && pend[i]) g = i;
        end
        cap_en    = !m_full || ordy;
        exp_sel   = (g < 0) ? m_ptr : g;
        exp_ready = (cap_en && g >= 0) ? (1 << g) : 0;
        chk("out_valid", int'(out_valid), int'(m_full));
        chk("in_ready", int'(in_ready), exp_ready);
        chk("sel", int'(sel), exp_sel);
        if (cap_en && g >= 0) begin
            sb.push_back('{d: word[g], s: 2'(g)});
            pend[g] = 1'b0;
            m_ptr   = (g + 1) % 4;
            m_full  = 1'b1;
        end else if (m_full && ordy) begin
            m_full = 1'b0;
        end
    endtask

    task automatic set_all(input logic [3:0] v);
        for (int i = 0; i < 4; i++) pend[i] = v[i];
    endtask

    // Monitor: every output handshake must match the oldest expected word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", int'(out_data), int'(e.d));
                    chk("out_src", int'(out_src), int'(e.s));
                end
            end
        end
    end

    initial begin
        model_reset();
        word[0] = 2'd3; word[1] = 2'd2; word[2] = 2'd1; word[3] = 2'd0;
        set_all(4'b1111);
        ordy    = 1'b1;
        rst_req = 1'b0;

        // Reset held with all requests up.
        repeat (3) step();
        rst_req = 1'b1;

        // Round-robin with continuous requests: data 3,2,1,0,3... src 0,1,2,3,0...
        repeat (6) begin
            set_all(4'b1111);
            step();
        end

        // Backpressure for 5 cycles, then resume.
        ordy = 1'b0;
        repeat (5) begin
            set_all(4'b1111);
            step();
        end
        ordy = 1'b1;
        repeat (4) begin
            set_all(4'b1111);
            step();
        end

        // Drain to empty, then single request on B followed by idle (ptr -> 2).
        set_all(4'b0000);
        repeat (2) step();
        pend[1] = 1'b1;
        step();
        repeat (2) step();

        // Sparse/wrap from ptr=2: D granted, then A after pointer wraps.
        pend[3] = 1'b1;
        step();
        pend[0] = 1'b1;
        step();
        repeat (2) step();

        // Random traffic.
        repeat (400) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 40) begin
                    pend[i] = 1'b1;
                    word[i] = DW'($urandom);
                end
            end
            ordy = ($urandom_range(0, 99) < 65);
            step();
        end

        // Mid-operation reset while FULL with backpressure.
        ordy = 1'b0;
        set_all(4'b1111);
        step();
        step();
        #1;
        rst_n   = 1'b0;
        rst_req = 1'b0;
        #1;
        chk("async_rst_out_valid", int'(out_valid), 0);
        model_reset();
        step();
        rst_req = 1'b1;
        ordy    = 1'b1;
        repeat (3) begin
            set_all(4'b1111);
            step();
        end

        // Final drain: every captured word must have been delivered.
        set_all(4'b0000);
        repeat (3) step();
        @(negedge clk);
        #4;
        chk("sb_empty_at_end", sb.size(), 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
